// File: rtl/k16_io_pkg.sv
`default_nettype none
// =============================================================================
// Module   : k16_io_pkg
// Brief    : Shared constants, types and slot-map helpers for the K16 nibble
//            I/O scanner.
// Revision : 1.0 - initial release
// =============================================================================
package k16_io_pkg;

  localparam int K16IO_SLOTS    = 8;
  localparam int K16IO_NIBBLE_W = 4;
  localparam int K16IO_WORD_W   = 16;
  localparam int K16IO_SLOT_W   = $clog2(K16IO_SLOTS);
  localparam int K16IO_FRAME_W  = 2 * K16IO_WORD_W;
  localparam int K16IO_DWELL_W  = 16;

  typedef logic [K16IO_SLOT_W-1:0]   slot_t;
  typedef logic [K16IO_NIBBLE_W-1:0] nibble_t;
  typedef logic [K16IO_WORD_W-1:0]   word_t;
  typedef logic [K16IO_FRAME_W-1:0]  frame_t;

  // Slots 0..3 address word 0, slots 4..7 address word 1, LSB nibble first.
  typedef struct packed {
    logic       word_sel;
    logic [1:0] nib_idx;
  } slot_map_t;

  function automatic slot_map_t slot_map(input slot_t slot);
    slot_map_t m;
    m.word_sel = slot[2];
    m.nib_idx  = slot[1:0];
    return m;
  endfunction

  function automatic nibble_t slot_nibble(input word_t w0, input word_t w1,
                                          input slot_t slot);
    slot_map_t m;
    word_t     w;
    m = slot_map(slot);
    w = m.word_sel ? w1 : w0;
    return w[{m.nib_idx, 2'b00} +: K16IO_NIBBLE_W];
  endfunction

  // A frame is {word1, word0}, so the slot index times four is the bit offset.
  function automatic frame_t frame_merge(input frame_t frame, input slot_t slot,
                                         input nibble_t nib);
    frame_t f;
    f = frame;
    f[{slot, 2'b00} +: K16IO_NIBBLE_W] = nib;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/k16_io_slot_timer.sv
`default_nettype none
// =============================================================================
// Module   : k16_io_slot_timer
// Brief    : Dwell counter and free-running 3-bit slot counter with a
//            combinational strobe flagging the last cycle of each slot.
// Revision : 1.0 - initial release
// =============================================================================
module k16_io_slot_timer
  import k16_io_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1
) (
  input  logic  clk,
  input  logic  reset,
  output slot_t slot,
  output logic  slot_end
);

  localparam logic [K16IO_DWELL_W-1:0] DWELL_LAST = K16IO_DWELL_W'(DWELL_CYCLES - 1);

  logic [K16IO_DWELL_W-1:0] dwell_q, dwell_d;
  slot_t                    slot_q, slot_d;
  logic                     last_w;

  always_comb begin
    last_w  = (dwell_q == DWELL_LAST);
    dwell_d = dwell_q + K16IO_DWELL_W'(1);
    slot_d  = slot_q;
    if (last_w) begin
      dwell_d = '0;
      slot_d  = slot_q + K16IO_SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q <= '0;
      slot_q  <= '0;
    end else begin
      dwell_q <= dwell_d;
      slot_q  <= slot_d;
    end
  end

  assign slot     = slot_q;
  assign slot_end = last_w;

endmodule
`default_nettype wire

// File: rtl/k16_io.sv
`default_nettype none
// =============================================================================
// Module   : k16_io
// Brief    : Time-multiplexed nibble I/O scanner: serialises two CPU output
//            words onto a 4-bit bus and gathers two input words frame-coherently.
//            Optional macro K16IO_INPUT_SYNC_EN adds a 2-flop input synchronizer.
// Revision : 1.0 - initial release
// =============================================================================
module k16_io
  import k16_io_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  select,
  output logic [3:0]  outputBits,
  input  logic [3:0]  inputBits,
  input  logic [15:0] cpuOutput0,
  input  logic [15:0] cpuOutput1,
  output logic [15:0] cpuInput0,
  output logic [15:0] cpuInput1
);

  localparam slot_t LAST_SLOT = slot_t'(K16IO_SLOTS - 1);

  slot_t scan_slot;
  logic  scan_slot_end;

  k16_io_slot_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .reset    (reset),
    .slot     (scan_slot),
    .slot_end (scan_slot_end)
  );

  // select/outputBits trail the timer by one edge; cap_q marks the final cycle
  // of the slot currently shown on select.
  slot_t   select_q, select_d;
  nibble_t out_nib_q, out_nib_d;
  logic    cap_q, cap_d;

  always_comb begin
    select_d  = scan_slot;
    out_nib_d = slot_nibble(cpuOutput0, cpuOutput1, scan_slot);
    cap_d     = scan_slot_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      select_q  <= '0;
      out_nib_q <= '0;
      cap_q     <= 1'b0;
    end else begin
      select_q  <= select_d;
      out_nib_q <= out_nib_d;
      cap_q     <= cap_d;
    end
  end

  nibble_t cap_nib;
  slot_t   cap_tag;
  logic    cap_en;

`ifdef K16IO_INPUT_SYNC_EN
  nibble_t sync1_q, sync1_d, sync2_q, sync2_d;
  slot_t   tag1_q, tag1_d, tag2_q, tag2_d;
  logic    cap1_q, cap1_d, cap2_q, cap2_d;

  // Slot tag and capture strobe ride alongside the data through both stages.
  always_comb begin
    sync1_d = inputBits;
    sync2_d = sync1_q;
    tag1_d  = select_q;
    tag2_d  = tag1_q;
    cap1_d  = cap_q;
    cap2_d  = cap1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      cap1_q  <= 1'b0;
      cap2_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
    end
  end

  assign cap_nib = sync2_q;
  assign cap_tag = tag2_q;
  assign cap_en  = cap2_q;
`else
  assign cap_nib = inputBits;
  assign cap_tag = select_q;
  assign cap_en  = cap_q;
`endif

  frame_t shadow_q, shadow_d;
  frame_t merged_w;
  word_t  in0_q, in0_d, in1_q, in1_d;

  always_comb begin
    merged_w = frame_merge(shadow_q, cap_tag, cap_nib);
    shadow_d = shadow_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    if (cap_en) begin
      shadow_d = merged_w;
      // Commit straight from the merged value so slot 7 lands in the same frame.
      if (cap_tag == LAST_SLOT) begin
        in0_d = merged_w[K16IO_WORD_W-1:0];
        in1_d = merged_w[K16IO_FRAME_W-1:K16IO_WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
    end
  end

  assign select     = select_q;
  assign outputBits = out_nib_q;
  assign cpuInput0  = in0_q;
  assign cpuInput1  = in1_q;

endmodule
`default_nettype wire

// File: tb/tb_k16_io.sv
`default_nettype none
// =============================================================================
// Module   : tb_k16_io
// Brief    : Self-checking bench for k16_io (DWELL 1 and 3 instances side by
//            side) against a slot/frame arithmetic reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_k16_io;

`ifdef K16IO_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int HIST_N = 2048;

  logic        clk;
  logic        reset;
  logic [3:0]  inputBits;
  logic [15:0] cpuOutput0, cpuOutput1;

  logic [2:0]  sel_a, sel_b;
  logic [3:0]  ob_a, ob_b;
  logic [15:0] ci0_a, ci1_a, ci0_b, ci1_b;

  k16_io #(.DWELL_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .select(sel_a), .outputBits(ob_a),
    .inputBits(inputBits), .cpuOutput0(cpuOutput0), .cpuOutput1(cpuOutput1),
    .cpuInput0(ci0_a), .cpuInput1(ci1_a)
  );

  k16_io #(.DWELL_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .select(sel_b), .outputBits(ob_b),
    .inputBits(inputBits), .cpuOutput0(cpuOutput0), .cpuOutput1(cpuOutput1),
    .cpuInput0(ci0_b), .cpuInput1(ci1_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  hist [HIST_N];
  logic [15:0] exp_ci0 [2];
  logic [15:0] exp_ci1 [2];
  int          e_next = 0;
  int          cur_e = 0;
  bit          cur_valid = 0;
  bit          phase_a = 0;
  int          mode = 0;
  logic [3:0]  scan_tbl [10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [15:0] w0, input logic [15:0] w1,
                                        input int s);
    logic [31:0] f;
    f = {w1, w0} >> (4 * s);
    return f[3:0];
  endfunction

  // Frame k ends at cycle 8*d*k-1; slot s was sampled on the last of its d cycles.
  task automatic model_commit(input int idx, input int d, input int e);
    int          base;
    logic [31:0] f;
    if ((e - LAT) > 0 && ((e - LAT) % (8 * d)) == 0) begin
      base = (e - LAT) - 8 * d;
      f = '0;
      for (int s = 0; s < 8; s++)
        f = f | ({28'd0, hist[base + s * d + d - 1]} << (4 * s));
      exp_ci0[idx] = f[15:0];
      exp_ci1[idx] = f[31:16];
    end
  endtask

  task automatic check_dut(input int idx, input int d, input int e,
                           input logic [2:0] sel, input logic [3:0] ob,
                           input logic [15:0] c0, input logic [15:0] c1);
    int s;
    s = (e / d) % 8;
    model_commit(idx, d, e);
    chk($sformatf("d%0d_select_e%0d", d, e), {29'd0, sel}, s);
    chk($sformatf("d%0d_outbits_e%0d", d, e), {28'd0, ob},
        {28'd0, nib_of(cpuOutput0, cpuOutput1, s)});
    chk($sformatf("d%0d_cpuin0_e%0d", d, e), {16'd0, c0}, {16'd0, exp_ci0[idx]});
    chk($sformatf("d%0d_cpuin1_e%0d", d, e), {16'd0, c1}, {16'd0, exp_ci1[idx]});
  endtask

  // Drive the coming cycle, then take one edge and check both instances.
  task automatic step(input logic nr);
    reset = nr;
    if (mode == 0) inputBits = cur_valid ? 4'(8 + cur_e % 8) : 4'h8;
    else           inputBits = 4'($urandom_range(0, 15));
    if (cur_valid && cur_e < HIST_N) hist[cur_e] = inputBits;
    @(posedge clk);
    #1;
    if (reset) begin
      chk("rst_select_a", {29'd0, sel_a}, 0);
      chk("rst_outbits_a", {28'd0, ob_a}, 0);
      chk("rst_cpuin0_a", {16'd0, ci0_a}, 0);
      chk("rst_cpuin1_a", {16'd0, ci1_a}, 0);
      chk("rst_select_b", {29'd0, sel_b}, 0);
      chk("rst_outbits_b", {28'd0, ob_b}, 0);
      chk("rst_cpuin0_b", {16'd0, ci0_b}, 0);
      chk("rst_cpuin1_b", {16'd0, ci1_b}, 0);
      for (int i = 0; i < 2; i++) begin
        exp_ci0[i] = '0;
        exp_ci1[i] = '0;
      end
      cur_valid = 0;
      e_next = 0;
    end else begin
      cur_e = e_next;
      e_next++;
      cur_valid = 1;
      check_dut(0, 1, cur_e, sel_a, ob_a, ci0_a, ci1_a);
      check_dut(1, 3, cur_e, sel_b, ob_b, ci0_b, ci1_b);
      if (phase_a && cur_e < 10) begin
        chk($sformatf("scan_tbl_sel_e%0d", cur_e), {29'd0, sel_a}, cur_e % 8);
        chk($sformatf("scan_tbl_ob_e%0d", cur_e), {28'd0, ob_a}, {28'd0, scan_tbl[cur_e]});
      end
      if (phase_a && cur_e == 8 + LAT) begin
        chk("gather_cpuin0", {16'd0, ci0_a}, 32'h0000_BA98);
        chk("gather_cpuin1", {16'd0, ci1_a}, 32'h0000_FEDC);
      end
    end
  endtask

  task automatic rand_outs();
    if ($urandom_range(0, 3) == 0) cpuOutput0 = 16'($urandom);
    if ($urandom_range(0, 3) == 0) cpuOutput1 = 16'($urandom);
  endtask

  initial begin
    bit done;
    scan_tbl = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3};
    for (int i = 0; i < HIST_N; i++) hist[i] = '0;
    exp_ci0 = '{16'h0, 16'h0};
    exp_ci1 = '{16'h0, 16'h0};
    reset      = 1'b1;
    inputBits  = 4'h0;
    cpuOutput0 = 16'h1234;
    cpuOutput1 = 16'h5678;

    repeat (250) step(1'b1);

    // Directed scan and gather with the 8..F input pattern.
    phase_a = 1;
    mode    = 0;
    repeat (20) step(1'b0);
    phase_a = 0;

    // Live update of word 1 while slot 5 is showing.
    done = 0;
    for (int i = 0; i < 30; i++) begin
      if (!done && cur_valid && (cur_e % 8) == 5) begin
        cpuOutput1 = 16'hAAAA;
        done = 1;
      end
      step(1'b0);
    end

    mode = 1;
    for (int i = 0; i < 200; i++) begin
      rand_outs();
      step(1'b0);
    end

    // One-cycle reset while slot 5 is showing on the DWELL=1 instance.
    for (int i = 0; i < 16 && !(cur_valid && (cur_e % 8) == 5); i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 300; i++) begin
      rand_outs();
      step(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k16_io.md
# k16_io

Time-multiplexed nibble I/O scanner for the K16 CPU. Scans two 16-bit CPU output words out over a 4-bit bus and gathers two 16-bit input words from a 4-bit bus. A 3-bit slot select drives external latches and multiplexers. Sits between the CPU's I/O registers and the board-level port logic.

## Interface
- DWELL_CYCLES, default 1: clock cycles each slot is held; legal range 1..65535.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- select  output  3  current slot index 0..7, registered.
- outputBits  output  4  nibble presented for the current slot, registered.
- inputBits  input  4  external nibble for the current slot.
- cpuOutput0  input  16  CPU output word 0.
- cpuOutput1  input  16  CPU output word 1.
- cpuInput0  output  16  gathered input word 0, registered, frame-coherent.
- cpuInput1  output  16  gathered input word 1, registered, frame-coherent.

## Operation
- Slot map for outputs:
  - slot s in 0..3 → cpuOutput0[4s+3:4s]
  - slot s in 4..7 → cpuOutput1[4(s-4)+3:4(s-4)]
- The same slot map applies to inputs: inputBits captured in slot s lands in the matching nibble of cpuInput0/1.
- Slot counter advances 0→1→…→7→0 every DWELL_CYCLES cycles and wraps freely.
- On each edge, outputBits is reloaded from the live cpuOutput nibble for the current slot. CPU writes therefore appear on the next edge for the active slot, and otherwise at the slot's next visit.
- Input capture:
  - inputBits is written into the 32-bit shadow register on the last cycle of slot s.
  - When slot 7's nibble is captured, cpuInput0/1 are loaded on that same edge from the shadow with the slot-7 nibble merged in.
  - cpuInput0/1 never show a partially updated frame.

## Timing
- While reset is high: select=0, outputBits=0, cpuInput0=0, cpuInput1=0, shadow=0, dwell counter=0.
- With DWELL_CYCLES=1, at the n-th rising edge after reset is sampled low (n=0,1,…):
  - select = n mod 8
  - outputBits = nibble(n mod 8) of the cpuOutput values sampled at that edge
- inputBits for slot s is captured at the edge that moves select away from s. With DWELL=1 that is edge n+1.
- cpuInput0/1 update once per 8×DWELL_CYCLES cycles. The first update happens at the edge ending the first slot 7 after reset.
- Reset asserted mid-frame discards the partial frame. Scanning restarts at slot 0 with a zeroed shadow.

## Configuration
- K16IO_INPUT_SYNC_EN defined:
  - inputBits passes through a 2-flop synchronizer before capture.
  - The slot tag used for capture is delayed by the same 2 cycles, so nibble-to-slot mapping is preserved.
  - Frame commit occurs 2 cycles later than the undefined case.
  - Synchronizer flops reset to 0.
- Undefined: inputBits is sampled directly, as described in Timing.

## Structure
- Shared package holds:
  - K16IO_SLOTS = 8
  - K16IO_NIBBLE_W = 4
  - K16IO_WORD_W = 16
  - the slot-to-word/nibble mapping helper
- One natural sub-module: k16_io_slot_timer, holding the dwell counter and 3-bit slot counter, with a slot-end strobe output.
- Output mux, shadow register, synchronizer and commit logic live in k16_io.

## Test plan
- Reset scan, DWELL=1: hold reset 250 cycles, then release with cpuOutput0=16'h1234 and cpuOutput1=16'h5678.
  - Required: 10 successive edges give select/outputBits of 0/4, 1/3, 2/2, 3/1, 4/8, 5/7, 6/6, 7/5, 0/4, 1/3.
- Input gather: drive inputBits = slot index + 8 (the pattern 8..F) during each slot.
  - Required: after the slot-7 commit edge, cpuInput0=16'hBA98 and cpuInput1=16'hFEDC.
  - Required: cpuInput0/1 unchanged at all other edges.
- Live update: change cpuOutput1 to 16'hAAAA while select=5.
  - Required: outputBits=A on the next edge and in slots 6, 7 and the next 4..7.
- Dwell: DWELL_CYCLES=3.
  - Required: select holds each value for 3 edges.
  - Required: capture occurs on the 3rd cycle of the slot.
  - Required: commit period is 24 cycles.
- Mid-frame reset: assert reset for 1 cycle while select=5.
  - Required: all outputs read 0 during reset.
  - Required: scanning resumes at select=0.
  - Required: no commit occurs until a full new frame completes.
- With K16IO_INPUT_SYNC_EN defined, repeat the input-gather scenario.
  - Required: same cpuInput values, committed 2 cycles later than without the macro.
